// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - encodings and FSM states shared by the execute-stage ALU/MDU.
// Optional divider support is enabled with the ALU_MDU_DIV_EN macro.
package alu_mdu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011100;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b100;
    localparam logic [2:0] CTRL_MUL = 3'b101;
    localparam logic [2:0] CTRL_SLT = 3'b110;
    localparam logic [2:0] CTRL_DIV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALUOp/funct decode to 3-bit ALU control.
// DIV funct is only recognised when ALU_MDU_DIV_EN is defined.
module alu_ctrl_dec
    import alu_mdu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: ctrl = CTRL_ADD;
                    FUNCT_SUB: ctrl = CTRL_SUB;
                    FUNCT_AND: ctrl = CTRL_AND;
                    FUNCT_OR:  ctrl = CTRL_OR;
                    FUNCT_SLT: ctrl = CTRL_SLT;
                    FUNCT_MUL: ctrl = CTRL_MUL;
`ifdef ALU_MDU_DIV_EN
                    FUNCT_DIV: ctrl = CTRL_DIV;
`endif
                    default: begin
                        ctrl    = CTRL_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl    = CTRL_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_mdu_unit.sv
// rtl/alu_mdu_unit.sv - registered ALU plus iterative multiplier behind valid/ready.
// Defining ALU_MDU_DIV_EN adds a restoring signed divider sharing the MUL state.
module alu_mdu_unit
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1      // 1, 2 or 4; must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam int MUL_CYCLES = WIDTH / MUL_STEP;
    localparam int CW         = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;

    logic [2:0]       ctrl;
    logic             dec_illegal;
    logic             is_multi;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] step_acc, step_plier, step_cand, step_res;
    logic [CW-1:0]    last_cnt;

`ifdef ALU_MDU_DIV_EN
    logic             div_q, div_neg_q, div_zero_q;
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_bit;
`endif

    alu_ctrl_dec u_dec (
        .alu_op  (alu_op),
        .funct   (funct),
        .ctrl    (ctrl),
        .illegal (dec_illegal)
    );

`ifdef ALU_MDU_DIV_EN
    assign is_multi = (ctrl == CTRL_MUL) || (ctrl == CTRL_DIV);
`else
    assign is_multi = (ctrl == CTRL_MUL);
`endif

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    always_comb begin
        alu_res = src_a + src_b;
        case (ctrl)
            CTRL_AND: alu_res = src_a & src_b;
            CTRL_OR:  alu_res = src_a | src_b;
            CTRL_SUB: alu_res = src_a - src_b;
            CTRL_SLT: begin
                alu_res    = '0;
                alu_res[0] = $signed(src_a) < $signed(src_b);
            end
            default:  alu_res = src_a + src_b;
        endcase
    end

    // One iteration: MUL adds MUL_STEP shifted partial products; DIV retires one quotient bit.
    always_comb begin
        step_acc = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                step_acc = step_acc + (mcand_q << i);
            end
        end
        step_plier = mplier_q >> MUL_STEP;
        step_cand  = mcand_q << MUL_STEP;
        step_res   = step_acc;
        last_cnt   = CW'(MUL_CYCLES - 1);
`ifdef ALU_MDU_DIV_EN
        div_shift = {acc_q, mplier_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        div_bit   = ~div_trial[WIDTH];
        if (div_q) begin
            step_acc   = div_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_plier = {mplier_q[WIDTH-2:0], div_bit};
            step_cand  = mcand_q;
            step_res   = div_zero_q ? '1 : (div_neg_q ? -step_plier : step_plier);
            last_cnt   = CW'(WIDTH - 1);
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = is_multi ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (cnt_q == last_cnt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_d = is_multi ? ST_MUL : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
`ifdef ALU_MDU_DIV_EN
            div_q      <= 1'b0;
            div_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else if (accept) begin
            illegal_q <= dec_illegal;
            cnt_q     <= '0;
            if (is_multi) begin
                acc_q    <= '0;
                mcand_q  <= src_a;
                mplier_q <= src_b;
`ifdef ALU_MDU_DIV_EN
                div_q      <= (ctrl == CTRL_DIV);
                div_neg_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                div_zero_q <= (src_b == '0);
                if (ctrl == CTRL_DIV) begin
                    // Divide magnitudes; the dividend shifts out of mplier_q as quotient bits shift in.
                    mcand_q  <= src_b[WIDTH-1] ? -src_b : src_b;
                    mplier_q <= src_a[WIDTH-1] ? -src_a : src_a;
                end
`endif
            end else begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
            end
        end else if (state_q == ST_MUL) begin
            cnt_q    <= cnt_q + CW'(1);
            acc_q    <= step_acc;
            mplier_q <= step_plier;
            mcand_q  <= step_cand;
            if (cnt_q == last_cnt) begin
                result_q <= step_res;
                zero_q   <= (step_res == '0);
            end
        end
    end

endmodule

// File: doc/alu_mdu_unit.md
Name: alu_mdu_unit

Overview:
- Execute-stage unit for the 32-bit MIPS datapath.
- Merges ALU control decode (ALUOp/Funct) with a registered ALU and an iterative shift-add multiplier behind a valid/ready handshake.
- Replaces the purely combinational decode-plus-ALU path so multicycle ops can stall the pipeline.
- Parametrised in datapath width and multiplier bits retired per cycle.

Parameters:
- WIDTH, 32: datapath width of src_a, src_b and result.
- MUL_STEP, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4; WIDTH must be divisible by MUL_STEP.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- alu_op  in  2  00 add, 01 sub, 10 use funct, 11 reserved.
- funct  in  6  R-type function field.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- illegal  out  1  result came from an unsupported alu_op/funct combination.
- busy  out  1  multicycle operation in progress.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, result=0, zero=0, illegal=0, busy=0. Any in-flight op is discarded with no output.
- Decode, 3-bit ctrl:
  - alu_op 00 -> ADD (010).
  - alu_op 01 -> SUB (100).
  - alu_op 10 with funct 100000 -> ADD; 100010 -> SUB; 100100 -> AND (000); 100101 -> OR (001); 101010 -> SLT (110); 011100 -> MUL (101).
  - Any other funct, or alu_op 11 -> ADD with illegal=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare: result is 1 or 0, zero-extended.
  - MUL returns the low WIDTH bits of the product; signedness is irrelevant for the low half.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) or (state==DONE and out_ready). Accept happens when in_valid and in_ready are both high at a rising edge.
- Single-cycle op accepted: next state DONE, result/zero/illegal registered, out_valid=1 the following cycle. Latency is 1.
- MUL accepted:
  - Operands latched; state MUL; busy=1.
  - Counter runs WIDTH/MUL_STEP cycles, each adding MUL_STEP partial products.
  - Then state DONE, out_valid=1. Latency is WIDTH/MUL_STEP + 1 cycles from accept.
- DONE with out_ready=0: result, zero and illegal are held stable and in_ready=0 (backpressure).
- DONE with out_ready=1 and no new accept: go to IDLE, out_valid=0.
- DONE with out_ready=1 and a new accept: back-to-back. The next op starts and there is no bubble for single-cycle ops.
- busy=1 only in MUL. in_valid during MUL is ignored.
- Inputs are sampled only at accept; later operand changes have no effect.

Optional Feature:
- Macro ALU_MDU_DIV_EN.
- Defined:
  - funct 011010 -> DIV (ctrl 111): signed quotient, truncated toward zero.
  - Restoring divider reuses the MUL state and counter; always 1 bit per cycle, WIDTH cycles, latency WIDTH+1.
  - Divide by zero -> result all ones, illegal=0.
  - Most-negative / -1 -> most-negative value.
- Not defined: funct 011010 decodes as illegal -> ADD with illegal=1. No divider logic is synthesised.

Decomposition:
- Package alu_mdu_pkg holds:
  - ALUOp encodings.
  - Funct codes: ADD, SUB, AND, OR, SLT, MUL, DIV.
  - 3-bit ALU control encodings.
  - State enum.
- Sub-module alu_ctrl_dec: combinational alu_op/funct -> ctrl plus illegal.
- Datapath and FSM stay in alu_mdu_unit.

Test Plan:
- Reset mid-MUL: accept MUL 7*6, assert rst_n=0 at cycle 3 -> out_valid=0, busy=0, result=0 immediately; no result ever emitted.
- Single-cycle ops:
  - alu_op=10, funct=100010, a=5, b=5 -> next cycle result=0, zero=1, out_valid=1.
  - funct=101010, a=0xFFFFFFFF, b=1 -> result=1.
- MUL latency:
  - WIDTH=32, MUL_STEP=1, a=0x0001_0000, b=0x0001_0000 -> result=0 (low half), out_valid exactly 33 cycles after accept, busy high for 32 cycles.
  - Repeat with MUL_STEP=4 -> 9 cycles.
- Backpressure: out_ready=0 for 5 cycles after result 3+4 -> result=7 held, in_ready=0. Then out_ready=1 with in_valid ADD 1+1 -> result=2 on the next cycle, no bubble.
- Illegal decode: alu_op=11, a=2, b=3 -> result=5, illegal=1. alu_op=10, funct=000000 -> illegal=1.
- With ALU_MDU_DIV_EN:
  - -7/2 -> 0xFFFFFFFD.
  - 9/0 -> 0xFFFFFFFF, illegal=0.
  - Without the macro, funct 011010 -> illegal=1 and result=a+b.
